// File: rtl/simon_pkg.sv
// SIMON 48/96 shared constants, state type and round helpers.
// Imported by the key schedule and the iterative core.
package simon_pkg;

    localparam int N  = 24;
    localparam int M  = 4;
    localparam int T  = 36;
    localparam int KX = T - M;

    // z1 written first-bit-leftmost; z1_bit() indexes from the left.
    localparam logic [61:0] Z1 =
        62'b10001110111110010011000010110101000111011111001001100001011010;

    typedef logic [N-1:0] word_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KEYEXP = 2'd1,
        S_RUN    = 2'd2,
        S_WAIT   = 2'd3
    } state_t;

    function automatic word_t rol(
        input word_t       v,
        input int unsigned s
    );
        return word_t'((v << s) | (v >> (N - s)));
    endfunction

    function automatic word_t ror(
        input word_t       v,
        input int unsigned s
    );
        return rol(v, N - s);
    endfunction

    function automatic word_t simon_f(input word_t x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic z1_bit(input logic [5:0] i);
        return Z1[6'd61 - i];
    endfunction

    function automatic word_t key_next(
        input word_t ki,
        input word_t ki1,
        input word_t ki3,
        input logic  zb
    );
        word_t tmp;
        tmp = ror(ki3, 3) ^ ki1;
        tmp = tmp ^ ror(tmp, 1);
        return ~ki ^ tmp ^ word_t'(zb) ^ word_t'(3);
    endfunction

endpackage

// File: rtl/simon_key_sched.sv
// SIMON 48/96 round-key file: loads k0..k3, then expands one
// key per clock; done_o stays high while the file is complete.
module simon_key_sched
    import simon_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [M-1:0][N-1:0] key_i,
    input  logic [5:0]         rd_addr_i,
    output word_t              rd_key_o,
    output logic               last_o,
    output logic               done_o
);

    word_t      rk_q [T];
    logic [4:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [5:0] base;
    word_t      k_new;

    assign base  = {1'b0, idx_q};
    assign k_new = key_next(rk_q[base],
                            rk_q[base + 6'd1],
                            rk_q[base + 6'd3],
                            z1_bit(base));

    assign last_o   = busy_q && (idx_q == 5'(KX - 1));
    assign done_o   = done_q;
    assign rd_key_o = rk_q[rd_addr_i];

    always_comb begin
        idx_d  = idx_q;
        busy_d = busy_q;
        done_d = done_q;
        if (load_i) begin
            idx_d  = '0;
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            idx_d = idx_q + 5'd1;
            if (last_o) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Key storage survives reset; done_q guards its validity.
    always_ff @(posedge clk) begin
        if (load_i) begin
            for (int i = 0; i < M; i++) begin
                rk_q[i] <= key_i[i];
            end
        end else if (busy_q) begin
            rk_q[base + 6'd4] <= k_new;
        end
    end

endmodule

// File: rtl/simon4896_iter_core.sv
// Iterative SIMON 48/96 encrypt/decrypt core, one round per clock,
// answering a level-driven host with load pulses and held results.
module simon4896_iter_core
    import simon_pkg::*;
(
    input  logic                clk,
    input  logic                R,
    input  logic                newKey,
    input  logic [M-1:0][N-1:0] KEY,
    output logic                loadKey,
    input  logic                newData,
    input  logic                enc_dec,
    input  logic [1:0][N-1:0]   blockIN,
    output logic                loadData,
    output logic                doneData,
    input  logic                readData,
    output logic [1:0][N-1:0]   outData,
    output logic [3:0]          mode
);

    state_t            state_q, state_d;
    logic [5:0]        rc_q, rc_d;
    word_t             x_q, x_d;
    word_t             y_q, y_d;
    logic              enc_q, enc_d;
    logic              ldk_q, ldk_d;
    logic              ldd_q, ldd_d;
    logic              done_q, done_d;
    logic [1:0][N-1:0] out_q, out_d;

    logic              ks_load;
    logic              ks_last;
    logic              key_valid;
    logic [5:0]        rk_addr;
    word_t             rk;
    word_t             xr, yr;
    logic              can_pub;

    simon_key_sched u_ks (
        .clk       (clk),
        .rst       (R),
        .load_i    (ks_load),
        .key_i     (KEY),
        .rd_addr_i (rk_addr),
        .rd_key_o  (rk),
        .last_o    (ks_last),
        .done_o    (key_valid)
    );

    assign rk_addr = enc_q ? rc_q : 6'(T - 1) - rc_q;

    always_comb begin
        if (enc_q) begin
            xr = y_q ^ simon_f(x_q) ^ rk;
            yr = x_q;
        end else begin
            xr = y_q;
            yr = x_q ^ simon_f(y_q) ^ rk;
        end
    end

    // A still-high readData blocks publishing so it acks only once.
    assign can_pub = !done_q && !readData;

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        x_d     = x_q;
        y_d     = y_q;
        enc_d   = enc_q;
        ldk_d   = 1'b0;
        ldd_d   = 1'b0;
        done_d  = done_q;
        out_d   = out_q;
        ks_load = 1'b0;

        if (done_q && readData) begin
            done_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (newKey) begin
                    ks_load = 1'b1;
                    ldk_d   = 1'b1;
                    state_d = S_KEYEXP;
                end else if (newData && key_valid) begin
                    x_d     = blockIN[1];
                    y_d     = blockIN[0];
                    enc_d   = enc_dec;
                    rc_d    = '0;
                    ldd_d   = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_KEYEXP: begin
                if (ks_last) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                x_d = xr;
                y_d = yr;
                if (rc_q == 6'(T - 1)) begin
                    if (can_pub) begin
                        out_d   = {xr, yr};
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    rc_d = rc_q + 6'd1;
                end
            end
            S_WAIT: begin
                if (can_pub) begin
                    out_d   = {x_q, y_q};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            state_q <= S_IDLE;
            rc_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            enc_q   <= 1'b0;
            ldk_q   <= 1'b0;
            ldd_q   <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            enc_q   <= enc_d;
            ldk_q   <= ldk_d;
            ldd_q   <= ldd_d;
            done_q  <= done_d;
            out_q   <= out_d;
        end
    end

    assign loadKey  = ldk_q;
    assign loadData = ldd_q;
    assign doneData = done_q;
    assign outData  = out_q;
    assign mode     = {key_valid, 1'b0, state_q};

endmodule

// File: tb/tb_simon4896_iter_core.sv
// Bench for simon4896_iter_core: handshake scenarios plus random
// blocks compared with a plain software model of SIMON 48/96.
module tb_simon4896_iter_core;

    logic             clk      = 1'b0;
    logic             R        = 1'b1;
    logic             newKey   = 1'b0;
    logic             newData  = 1'b0;
    logic             enc_dec  = 1'b0;
    logic             readData = 1'b0;
    logic [3:0][23:0] KEY      = '0;
    logic [1:0][23:0] blockIN  = '0;
    logic             loadKey;
    logic             loadData;
    logic             doneData;
    logic [1:0][23:0] outData;
    logic [3:0]       mode;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [95:0] TV_KEY = 96'h1a1918_121110_0a0908_020100;
    localparam logic [47:0] TV_PT  = 48'h726963_20646e;
    localparam logic [47:0] TV_CT  = 48'h6e06a5_acf156;

    always #5 clk = ~clk;

    simon4896_iter_core dut (
        .clk      (clk),
        .R        (R),
        .newKey   (newKey),
        .KEY      (KEY),
        .loadKey  (loadKey),
        .newData  (newData),
        .enc_dec  (enc_dec),
        .blockIN  (blockIN),
        .loadData (loadData),
        .doneData (doneData),
        .readData (readData),
        .outData  (outData),
        .mode     (mode)
    );

    function automatic logic [23:0] rotl(
        input logic [23:0] v,
        input int          s
    );
        logic [23:0] o;
        for (int i = 0; i < 24; i++) o[(i + s) % 24] = v[i];
        return o;
    endfunction

    function automatic logic [23:0] fx(input logic [23:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

    function automatic logic [47:0] model(
        input logic [95:0] key,
        input logic [47:0] blk,
        input bit          enc
    );
        string z =
          "10001110111110010011000010110101000111011111001001100001011010";
        logic [23:0] k [36];
        logic [23:0] x, y, t;
        for (int i = 0; i < 4; i++) k[i] = key[24*i +: 24];
        for (int i = 0; i < 32; i++) begin
            t = rotl(k[i+3], 21) ^ k[i+1];
            t = t ^ rotl(t, 23);
            k[i+4] = ~k[i] ^ t ^ 24'd3
                   ^ ((z[i] == 8'h31) ? 24'd1 : 24'd0);
        end
        x = blk[47:24];
        y = blk[23:0];
        for (int r = 0; r < 36; r++) begin
            if (enc) begin
                t = x;
                x = y ^ fx(x) ^ k[r];
                y = t;
            end else begin
                t = y;
                y = x ^ fx(y) ^ k[35-r];
                x = t;
            end
        end
        return {x, y};
    endfunction

    function automatic bit sig(input int sel);
        case (sel)
            0:       return loadKey;
            1:       return loadData;
            default: return doneData;
        endcase
    endfunction

    // Negedges until the selected output is high; -1 on timeout.
    task automatic wait_sig(input int sel, input int lim, output int cyc);
        bit hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < lim) begin
            @(negedge clk);
            cyc++;
            hit = sig(sel);
        end
        if (!hit) cyc = -1;
    endtask

    task automatic host_read();
        readData = 1'b1;
        @(negedge clk);
        readData = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        R = 1'b1;
        for (int i = 0; i < 8; i++) begin
            {newKey, newData, enc_dec, readData} = 4'($urandom);
            KEY     = {$urandom, $urandom, $urandom};
            blockIN = 48'({$urandom, $urandom});
            @(negedge clk);
            total_cnt++;
            if ({loadKey, loadData, doneData, outData, mode} !== '0)
                $display("FAIL reset_outputs: got %b %b %b %h %h want 0",
                         loadKey, loadData, doneData, outData, mode);
            else pass_cnt++;
        end
        newKey   = 1'b0;
        readData = 1'b0;
        newData  = 1'b1;
        R        = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (loadData) n++;
        end
        newData = 1'b0;
        total_cnt++;
        if (n != 0 || mode !== 4'h0)
            $display("FAIL nokey_hold: loadData %0d mode %h want 0 0",
                     n, mode);
        else pass_cnt++;
    endtask

    task automatic test_encrypt();
        int c;
        KEY     = TV_KEY;
        blockIN = TV_PT;
        enc_dec = 1'b1;
        newKey  = 1'b1;
        newData = 1'b1;
        wait_sig(0, 10, c);
        newKey = 1'b0;
        total_cnt++;
        if (c != 1) $display("FAIL tv_loadkey: cycles %0d want 1", c);
        else pass_cnt++;
        total_cnt++;
        if (mode !== 4'h1) $display("FAIL tv_mode_kx: got %h want 1", mode);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (loadKey !== 1'b0)
            $display("FAIL tv_loadkey_pulse: got %b want 0", loadKey);
        else pass_cnt++;
        wait_sig(1, 60, c);
        newData = 1'b0;
        total_cnt++;
        if (c != 32)
            $display("FAIL tv_loaddata_lat: got %0d want 33", c + 1);
        else pass_cnt++;
        total_cnt++;
        if (mode !== 4'hA) $display("FAIL tv_mode_run: got %h want a", mode);
        else pass_cnt++;
        wait_sig(2, 60, c);
        total_cnt++;
        if (c != 36) $display("FAIL tv_enc_lat: got %0d want 36", c);
        else pass_cnt++;
        total_cnt++;
        if (outData !== TV_CT)
            $display("FAIL tv_enc: got %h want %h", outData, TV_CT);
        else pass_cnt++;
        total_cnt++;
        if (mode !== 4'h8) $display("FAIL tv_mode_idle: got %h want 8", mode);
        else pass_cnt++;
        host_read();
        total_cnt++;
        if (doneData !== 1'b0 || outData !== TV_CT)
            $display("FAIL tv_read: done %b out %h want 0 %h",
                     doneData, outData, TV_CT);
        else pass_cnt++;
    endtask

    task automatic test_decrypt();
        int c;
        blockIN = TV_CT;
        enc_dec = 1'b0;
        newData = 1'b1;
        wait_sig(1, 10, c);
        newData = 1'b0;
        total_cnt++;
        if (c != 1) $display("FAIL tv_dec_load: got %0d want 1", c);
        else pass_cnt++;
        wait_sig(2, 60, c);
        total_cnt++;
        if (c != 36 || outData !== TV_PT)
            $display("FAIL tv_dec: lat %0d out %h want 36 %h",
                     c, outData, TV_PT);
        else pass_cnt++;
        host_read();
    endtask

    task automatic test_random();
        int c;
        logic [95:0] key;
        logic [47:0] blk;
        logic [47:0] exp;
        bit e;
        for (int kk = 0; kk < 3; kk++) begin
            key    = {$urandom, $urandom, $urandom};
            KEY    = key;
            newKey = 1'b1;
            wait_sig(0, 10, c);
            newKey = 1'b0;
            for (int b = 0; b < 3; b++) begin
                blk     = 48'({$urandom, $urandom});
                e       = 1'($urandom);
                exp     = model(key, blk, e);
                blockIN = blk;
                enc_dec = e;
                newData = 1'b1;
                wait_sig(1, 60, c);
                newData = 1'b0;
                wait_sig(2, 60, c);
                total_cnt++;
                if (c != 36 || outData !== exp)
                    $display("FAIL rand_blk: lat %0d out %h want 36 %h",
                             c, outData, exp);
                else pass_cnt++;
                host_read();
            end
        end
    endtask

    task automatic test_stream();
        logic [47:0] exp_q[$];
        int  delays[5] = '{50, 10, 60, 10, 10};
        int  saw_wait  = 0;
        int  extra     = 0;
        bit  stop      = 1'b0;
        fork
            begin : feeder
                for (int i = 0; i < 5; i++) begin
                    logic [47:0] blk;
                    bit e;
                    int c;
                    blk = 48'({$urandom, $urandom});
                    e   = 1'($urandom);
                    @(negedge clk);
                    blockIN = blk;
                    enc_dec = e;
                    newData = 1'b1;
                    wait_sig(1, 400, c);
                    newData = 1'b0;
                    total_cnt++;
                    if (c < 0) $display("FAIL stream_load: blk %0d timeout", i);
                    else pass_cnt++;
                    exp_q.push_back(model(KEY, blk, e));
                end
            end
            begin : reader
                for (int i = 0; i < 5; i++) begin
                    int c;
                    wait_sig(2, 400, c);
                    total_cnt++;
                    if (c < 0 || exp_q.size() == 0)
                        $display("FAIL stream_done: blk %0d cyc %0d q %0d",
                                 i, c, exp_q.size());
                    else if (outData !== exp_q[0])
                        $display("FAIL stream_data: blk %0d got %h want %h",
                                 i, outData, exp_q[0]);
                    else pass_cnt++;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    repeat (delays[i]) @(negedge clk);
                    host_read();
                    total_cnt++;
                    if (doneData !== 1'b0)
                        $display("FAIL stream_ack: blk %0d done %b want 0",
                                 i, doneData);
                    else pass_cnt++;
                end
                stop = 1'b1;
            end
            begin : monitor
                while (!stop) begin
                    @(negedge clk);
                    if (mode[1:0] == 2'b11) saw_wait++;
                end
            end
        join
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (doneData) extra++;
        end
        total_cnt++;
        if (saw_wait == 0 || extra != 0)
            $display("FAIL stream_wait: wait %0d extra %0d want >0 0",
                     saw_wait, extra);
        else pass_cnt++;
    endtask

    task automatic test_newkey_run();
        int c;
        int n;
        int lk = 0;
        logic [95:0] oldk;
        logic [95:0] nk;
        logic [47:0] blk;
        logic [47:0] exp;
        oldk    = KEY;
        nk      = {$urandom, $urandom, $urandom};
        blk     = 48'({$urandom, $urandom});
        exp     = model(oldk, blk, 1'b1);
        blockIN = blk;
        enc_dec = 1'b1;
        newData = 1'b1;
        wait_sig(1, 60, c);
        newData = 1'b0;
        repeat (5) @(negedge clk);
        KEY    = nk;
        newKey = 1'b1;
        n      = 5;
        while (!doneData && n < 100) begin
            @(negedge clk);
            n++;
            if (loadKey) lk++;
        end
        total_cnt++;
        if (lk != 0 || n != 36 || outData !== exp)
            $display("FAIL nk_run: lk %0d lat %0d out %h want 0 36 %h",
                     lk, n, outData, exp);
        else pass_cnt++;
        wait_sig(0, 10, c);
        newKey = 1'b0;
        total_cnt++;
        if (c != 1) $display("FAIL nk_after: got %0d want 1", c);
        else pass_cnt++;
        host_read();
        blk     = 48'({$urandom, $urandom});
        exp     = model(nk, blk, 1'b1);
        blockIN = blk;
        newData = 1'b1;
        wait_sig(1, 60, c);
        newData = 1'b0;
        wait_sig(2, 60, c);
        total_cnt++;
        if (outData !== exp)
            $display("FAIL nk_newkey: got %h want %h", outData, exp);
        else pass_cnt++;
        host_read();
    endtask

    task automatic test_reset_mid();
        int c;
        int ld = 0;
        int dn = 0;
        blockIN = 48'({$urandom, $urandom});
        enc_dec = 1'b1;
        newData = 1'b1;
        wait_sig(1, 60, c);
        newData = 1'b0;
        repeat (20) @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({doneData, outData, mode} !== '0)
            $display("FAIL rst_run: done %b out %h mode %h want 0",
                     doneData, outData, mode);
        else pass_cnt++;
        R       = 1'b0;
        newData = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (loadData) ld++;
            if (doneData) dn++;
        end
        newData = 1'b0;
        total_cnt++;
        if (ld != 0 || dn != 0)
            $display("FAIL rst_run_after: load %0d done %0d want 0 0",
                     ld, dn);
        else pass_cnt++;
        KEY    = {$urandom, $urandom, $urandom};
        newKey = 1'b1;
        wait_sig(0, 10, c);
        newKey = 1'b0;
        repeat (10) @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        R       = 1'b0;
        newData = 1'b1;
        ld      = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (loadData) ld++;
        end
        newData = 1'b0;
        total_cnt++;
        if (ld != 0 || mode !== 4'h0)
            $display("FAIL rst_kx: load %0d mode %h want 0 0", ld, mode);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_random();
        test_stream();
        test_newkey_run();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
